// File: rtl/rtc_ad_bus_engine.sv
`default_nettype none
// ============================================================================
// Module   : rtc_ad_bus_engine
// Purpose  : Transaction engine for the RTC multiplexed address/data bus.
//            Accepts one read/write command per handshake and runs complete
//            address + data cycles (setup / strobe / hold / gap per phase)
//            with parameterised phase timing.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            cmd_valid/cmd_ready   - command handshake (ready only when idle)
//            cmd_write/addr/len    - command fields, latched on accept
//            wr_data / wr_take     - write data and its consume pulse
//            rd_data / rd_valid    - last read byte and its update pulse
//            beat_idx, busy, done  - progress / status
//            a_d, cs, rd, wr       - bus controls (cs/rd/wr active low)
//            ad_out, ad_oe, ad_in  - AD bus drive value, enable, read-back
// Config   : RTC_BURST_EN - when defined, cmd_len selects 1..2**LEN_W beats
//            with auto-incrementing address; otherwise every command is a
//            single beat and cmd_len is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_ad_bus_engine #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int T_SU   = 2,
    parameter int T_ST   = 4,
    parameter int T_HD   = 2,
    parameter int T_GAP  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_take,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              busy,
    output logic              done,
    output logic              a_d,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in
);

    // Phase counter only has to reach the longest phase minus one.
    localparam int c_T_MAX_A = (T_SU > T_ST) ? T_SU : T_ST;
    localparam int c_T_MAX_B = (T_HD > T_GAP) ? T_HD : T_GAP;
    localparam int c_T_MAX   = (c_T_MAX_A > c_T_MAX_B) ? c_T_MAX_A : c_T_MAX_B;
    localparam int c_CNT_W   = (c_T_MAX > 1) ? $clog2(c_T_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_SU_LAST  = c_CNT_W'(T_SU - 1);
    localparam logic [c_CNT_W-1:0] c_ST_LAST  = c_CNT_W'(T_ST - 1);
    localparam logic [c_CNT_W-1:0] c_HD_LAST  = c_CNT_W'(T_HD - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(T_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_A_SU  = 4'd1,
        S_A_ST  = 4'd2,
        S_A_HD  = 4'd3,
        S_A_GAP = 4'd4,
        S_D_SU  = 4'd5,
        S_D_ST  = 4'd6,
        S_D_HD  = 4'd7,
        S_D_GAP = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_last;
    logic                r_write;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic [LEN_W-1:0]    w_beat;
    logic [DATA_W-1:0]   w_addr_beat;
    logic                w_last_beat;
    logic                w_phase_end;
    logic                w_accept;
    logic                w_rd_capture;

`ifdef RTC_BURST_EN
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_beat;

    assign w_beat      = r_beat;
    assign w_last_beat = (r_beat == r_len);

    // Beat index restarts on accept and returns to zero after the final
    // beat so an idle engine always reports beat 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len  <= '0;
            r_beat <= '0;
        end else if (w_accept) begin
            r_len  <= cmd_len;
            r_beat <= '0;
        end else if ((r_state == S_D_GAP) && w_phase_end) begin
            r_beat <= w_last_beat ? '0 : (r_beat + LEN_W'(1));
        end
    end
`else
    logic                w_unused_len;

    assign w_beat       = '0;
    assign w_last_beat  = 1'b1;
    assign w_unused_len = ^cmd_len;
`endif

    // Address for the current beat wraps modulo 2**DATA_W.
    assign w_addr_beat  = r_addr + DATA_W'(w_beat);

    assign w_accept     = (r_state == S_IDLE) && cmd_valid;
    assign w_phase_end  = (r_cnt == w_cnt_last);
    assign w_rd_capture = (r_state == S_D_ST) && w_phase_end && !r_write;

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_D_GAP) && w_phase_end && w_last_beat;
    assign wr_take   = (r_state == S_D_SU) && (r_cnt == '0) && r_write;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign beat_idx  = w_beat;

    // Terminal count of the current phase; kept separate from the main
    // decode so the phase-end flag does not loop back through it.
    always_comb begin
        w_cnt_last = '0;
        case (r_state)
            S_A_SU,  S_D_SU:  w_cnt_last = c_SU_LAST;
            S_A_ST,  S_D_ST:  w_cnt_last = c_ST_LAST;
            S_A_HD,  S_D_HD:  w_cnt_last = c_HD_LAST;
            S_A_GAP, S_D_GAP: w_cnt_last = c_GAP_LAST;
            default:          w_cnt_last = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) || w_phase_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_accept) begin
                r_write <= cmd_write;
                r_addr  <= cmd_addr;
            end
            if (wr_take) begin
                r_wdata <= wr_data;
            end
            // ad_in is sampled at the end of the strobe, so the byte shows
            // up together with the first hold cycle.
            r_rd_valid <= w_rd_capture;
            if (w_rd_capture) begin
                r_rd_data <= ad_in;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        a_d          = 1'b1;
        cs           = 1'b1;
        rd           = 1'b1;
        wr           = 1'b1;
        ad_oe        = 1'b0;
        ad_out       = '0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next_state = S_A_SU;
            end
            S_A_SU: begin
                a_d    = 1'b0;
                ad_oe  = 1'b1;
                ad_out = w_addr_beat;
                if (w_phase_end) w_next_state = S_A_ST;
            end
            // The address is latched by the chip on a write strobe with
            // a_d low, regardless of the command direction.
            S_A_ST: begin
                a_d    = 1'b0;
                ad_oe  = 1'b1;
                ad_out = w_addr_beat;
                cs     = 1'b0;
                wr     = 1'b0;
                if (w_phase_end) w_next_state = S_A_HD;
            end
            S_A_HD: begin
                a_d    = 1'b0;
                ad_oe  = 1'b1;
                ad_out = w_addr_beat;
                if (w_phase_end) w_next_state = S_A_GAP;
            end
            S_A_GAP: begin
                if (w_phase_end) w_next_state = S_D_SU;
            end
            S_D_SU: begin
                ad_oe  = r_write;
                ad_out = r_write ? r_wdata : '0;
                if (w_phase_end) w_next_state = S_D_ST;
            end
            S_D_ST: begin
                ad_oe  = r_write;
                ad_out = r_write ? r_wdata : '0;
                cs     = 1'b0;
                wr     = !r_write;
                rd     = r_write;
                if (w_phase_end) w_next_state = S_D_HD;
            end
            S_D_HD: begin
                ad_oe  = r_write;
                ad_out = r_write ? r_wdata : '0;
                if (w_phase_end) w_next_state = S_D_GAP;
            end
            S_D_GAP: begin
                if (w_phase_end) w_next_state = w_last_beat ? S_IDLE : S_A_SU;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rtc_ad_bus_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rtc_ad_bus_engine
// Purpose  : Self-checking bench for rtc_ad_bus_engine. A cycle-offset model
//            predicts every bus output from the command timeline; directed
//            tests add hand-computed expectations on strobe contents,
//            pulse counts and done latency.
// Config   : honours RTC_BURST_EN for the burst/non-burst expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_ad_bus_engine;

    localparam int T_SU  = 2;
    localparam int T_ST  = 4;
    localparam int T_HD  = 2;
    localparam int T_GAP = 3;
    localparam int PH    = T_SU + T_ST + T_HD + T_GAP;
    localparam int BEAT  = 2 * PH;
`ifdef RTC_BURST_EN
    localparam int BURST_BEATS = 3;
`else
    localparam int BURST_BEATS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [3:0] cmd_len = 4'h0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_take;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] beat_idx;
    logic       busy;
    logic       done;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in = 8'h00;

    always #5 clk = ~clk;

    rtc_ad_bus_engine #(
        .DATA_W (8),
        .LEN_W  (4),
        .T_SU   (T_SU),
        .T_ST   (T_ST),
        .T_HD   (T_HD),
        .T_GAP  (T_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_take   (wr_take),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .beat_idx  (beat_idx),
        .busy      (busy),
        .done      (done),
        .a_d       (a_d),
        .cs        (cs),
        .rd        (rd),
        .wr        (wr),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .ad_in     (ad_in)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit mon_en       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- behavioural model (cycle offset within command) -------
    bit         m_busy  = 1'b0;
    int         m_k     = 0;
    int         m_beats = 1;
    logic       m_write = 1'b0;
    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wd    = 8'h00;
    logic [7:0] m_rd    = 8'h00;

    always @(posedge clk) begin : model
        int p;
        int half;
        int q;
        if (reset) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_rd   = 8'h00;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy  = 1'b1;
                m_k     = 1;
                m_write = cmd_write;
                m_addr  = cmd_addr;
`ifdef RTC_BURST_EN
                m_beats = int'(cmd_len) + 1;
`else
                m_beats = 1;
`endif
            end
        end else begin
            p    = (m_k - 1) % BEAT;
            half = p / PH;
            q    = p % PH;
            if (half == 1 && q == 0 && m_write) m_wd = wr_data;
            if (half == 1 && q == T_SU + T_ST - 1 && !m_write) m_rd = ad_in;
            if (m_k == BEAT * m_beats) m_busy = 1'b0;
            else m_k++;
        end
    end

    // ---------------- observation log for directed checks ------------------
    logic [10:0] strobes[$];
    int          acc_edges[$];
    int          n_take = 0;
    int          n_rv = 0;
    int          n_done = 0;
    int          done_off = -1;
    int          cur_edge = 0;
    int          n_data_oe = 0;
    int          n_data_wr0 = 0;
    logic [7:0]  rv_data = 8'h00;

    always @(negedge clk) begin : compare
        int         p;
        int         half;
        int         q;
        int         b;
        bit         active;
        bit         strobe;
        bit         chk_out;
        logic       e_ad, e_cs, e_rd, e_wr, e_oe, e_take, e_rv, e_done;
        logic [7:0] e_out;
        logic [3:0] e_beat;
        e_ad = 1'b1; e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_oe = 1'b0;
        e_take = 1'b0; e_rv = 1'b0; e_done = 1'b0; e_out = 8'h00; e_beat = 4'h0;
        chk_out = 1'b1;
        if (m_busy) begin
            p      = (m_k - 1) % BEAT;
            b      = (m_k - 1) / BEAT;
            half   = p / PH;
            q      = p % PH;
            active = (q < T_SU + T_ST + T_HD);
            strobe = (q >= T_SU) && (q < T_SU + T_ST);
            e_ad   = !(half == 0 && active);
            e_cs   = !strobe;
            e_wr   = !(strobe && (half == 0 || m_write));
            e_rd   = !(strobe && half == 1 && !m_write);
            e_oe   = active && (half == 0 || m_write);
            if (active && half == 0) e_out = 8'(int'(m_addr) + b);
            else if (active && m_write) e_out = m_wd;
            chk_out = !(half == 1 && m_write && q == 0);
            e_take = (half == 1 && m_write && q == 0);
            e_rv   = (half == 1 && !m_write && q == T_SU + T_ST);
            e_done = (m_k == BEAT * m_beats);
            e_beat = 4'(b);
        end
        if (mon_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            check("busy",      32'(busy),      32'(m_busy));
            check("a_d",       32'(a_d),       32'(e_ad));
            check("cs",        32'(cs),        32'(e_cs));
            check("rd",        32'(rd),        32'(e_rd));
            check("wr",        32'(wr),        32'(e_wr));
            check("ad_oe",     32'(ad_oe),     32'(e_oe));
            if (chk_out) check("ad_out", 32'(ad_out), 32'(e_out));
            check("wr_take",   32'(wr_take),   32'(e_take));
            check("rd_valid",  32'(rd_valid),  32'(e_rv));
            check("rd_data",   32'(rd_data),   32'(m_rd));
            check("done",      32'(done),      32'(e_done));
            check("beat_idx",  32'(beat_idx),  32'(e_beat));
            if (cs == 1'b0) strobes.push_back({a_d, rd, wr, ad_out});
            if (wr_take) n_take++;
            if (rd_valid) begin
                n_rv++;
                rv_data = rd_data;
            end
            if (done) begin
                n_done++;
                if (done_off < 0) done_off = cyc - cur_edge + 1;
            end
            if (busy && a_d && ad_oe) n_data_oe++;
            if (busy && a_d && !wr) n_data_wr0++;
            if (cmd_valid && cmd_ready && !reset) acc_edges.push_back(cyc + 1);
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic clear_log();
        strobes.delete();
        acc_edges.delete();
        n_take = 0; n_rv = 0; n_done = 0; done_off = -1;
        n_data_oe = 0; n_data_wr0 = 0;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l, input logic [7:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; wr_data = d;
        @(posedge clk); #1;
        cur_edge  = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " idle within budget"}, 32'(busy), 32'(0));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ---------------------------------------
    initial begin : stim
        logic [10:0] exp_s;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check("rst cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst busy",      32'(busy),      32'(0));
        check("rst bus",       32'({a_d, cs, rd, wr, ad_oe}), 32'(5'b11110));
        check("rst ad_out",    32'(ad_out),    32'(8'h00));
        check("rst rd_data",   32'(rd_data),   32'(8'h00));

        // 1: single write
        clear_log();
        issue(1'b1, 8'h21, 4'h0, 8'h45);
        wait_idle(60, "t1");
        check("t1 done count", 32'(n_done), 32'(1));
        check("t1 done cycle", 32'(done_off), 32'(22));
        check("t1 wr_take count", 32'(n_take), 32'(1));
        check("t1 strobe count", 32'(strobes.size()), 32'(8));
        if (strobes.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                exp_s = (i < 4) ? 11'b0_1_0_00100001 : 11'b1_1_0_01000101;
                check($sformatf("t1 strobe%0d", i), 32'(strobes[i]), 32'(exp_s));
            end
        end

        // 2: single read
        clear_log();
        ad_in = 8'h37;
        issue(1'b0, 8'h41, 4'h0, 8'h00);
        wait_idle(60, "t2");
        check("t2 rd_valid count", 32'(n_rv), 32'(1));
        check("t2 rd_valid data",  32'(rv_data), 32'(8'h37));
        check("t2 rd_data held",   32'(rd_data), 32'(8'h37));
        check("t2 data oe cycles", 32'(n_data_oe), 32'(0));
        check("t2 data wr low",    32'(n_data_wr0), 32'(0));
        check("t2 strobe count",   32'(strobes.size()), 32'(8));
        if (strobes.size() == 8) begin
            check("t2 addr strobe", 32'(strobes[0]), 32'(11'b0_1_0_01000001));
            check("t2 data strobe", 32'(strobes[7]), 32'(11'b1_0_1_00000000));
        end

        // 3/4: write 0xFE len 2 (burst or single depending on build)
        clear_log();
        issue(1'b1, 8'hFE, 4'h2, 8'h5A);
        wait_idle(150, "t3");
        check("t3 done count", 32'(n_done), 32'(1));
        check("t3 done cycle", 32'(done_off), 32'(BEAT * BURST_BEATS));
        check("t3 wr_take count", 32'(n_take), 32'(BURST_BEATS));
        check("t3 strobe count", 32'(strobes.size()), 32'(8 * BURST_BEATS));
        if (strobes.size() == 8 * BURST_BEATS) begin
            for (int i = 0; i < BURST_BEATS; i++) begin
                for (int j = 0; j < 8; j++) begin
                    if (j < 4) exp_s = {3'b010, 8'(8'hFE + 8'(i))};
                    else       exp_s = {3'b110, 8'h5A};
                    check($sformatf("t3 beat%0d strobe%0d", i, j), 32'(strobes[i*8+j]), 32'(exp_s));
                end
            end
        end

        // 5: reset in the middle of a read strobe
        clear_log();
        ad_in = 8'h99;
        issue(1'b0, 8'h30, 4'h0, 8'h00);
        repeat (14) @(posedge clk);
        #1;
        check("t5 in strobe", 32'({a_d, cs, rd}), 32'(3'b100));
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5 bus after reset", 32'({cs, rd, wr, ad_oe}), 32'(4'b1110));
        check("t5 idle after reset", 32'({busy, cmd_ready}), 32'(2'b01));
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("t5 no done", 32'(n_done), 32'(0));
        check("t5 no rd_valid", 32'(n_rv), 32'(0));

        // 6: cmd_valid held through busy
        clear_log();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_len = 4'h0; wr_data = 8'h77;
        for (int n = 0; n < 80 && acc_edges.size() < 2; n++) begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("t6 accepts", 32'(acc_edges.size()), 32'(2));
        if (acc_edges.size() == 2)
            check("t6 accept spacing", 32'(acc_edges[1] - acc_edges[0]), 32'(23));
        check("t6 first done count", 32'(n_done), 32'(1));
        wait_idle(60, "t6");
        check("t6 total done", 32'(n_done), 32'(2));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
